nway_wb_cache: RTL

NWAY_WB_CACHE -- requirements
Module: nway_wb_cache

---
 rtl/nway_wb_cache_pkg.sv | 29 ++
 rtl/nway_wb_cache_if.sv | 32 +++
 rtl/nway_wb_cache_lru_ctrl.sv | 43 ++++
 rtl/nway_wb_cache.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/nway_wb_cache_pkg.sv
// Shared definitions for the N-way write-back cache.
//   state_e  : miss-handling FSM states (IDLE, WB, FILL)
//   clog2w   : ceiling log2 used to size index, tag and age fields
//   sat_inc  : 32-bit saturating increment for the hit/miss counters
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WB   = 2'b01,
    FILL = 2'b10
  } state_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic int clog2w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == CNT_MAX) return v;
    else return v + 32'd1;
  endfunction

endpackage

// File: rtl/nway_wb_cache_if.sv
// CPU-side and memory-side bus of the cache.
//   slave  : the cache's view (takes CPU requests and memory responses)
//   master : the environment's view (CPU + backing memory)
// Signals: cpu_re/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/stall,
//          mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ack,
//          hit_cnt/miss_cnt statistics.
interface nway_wb_cache_if #(parameter int AW = 32);
  logic          cpu_re;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/nway_wb_cache_lru_ctrl.sv
// LRU age update and victim selection for one set (purely combinational).
//   ages_i   : current ages of the set, a permutation of 0..WAYS-1
//   valid_i  : valid bits of the set
//   way_i    : way being accessed (hit or fill)
//   ages_o   : ages after touching way_i
//   victim_o : lowest invalid way, else the way with the oldest age
module lru_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int WW   = 2
) (
  input  logic [WAYS-1:0][WW-1:0] ages_i,
  input  logic [WAYS-1:0]         valid_i,
  input  logic [WW-1:0]           way_i,
  output logic [WAYS-1:0][WW-1:0] ages_o,
  output logic [WW-1:0]           victim_o
);

  // Victim: oldest way first, then overridden by the lowest-index invalid way.
  always_comb begin
    victim_o = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (ages_i[i] == WW'(WAYS - 1)) victim_o = WW'(i);
      else victim_o = victim_o;
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_o = WW'(i);
      else victim_o = victim_o;
    end
  end

  // Touched way becomes youngest; ways younger than it age by one.
  always_comb begin
    ages_o = ages_i;
    for (int i = 0; i < WAYS; i++) begin
      if (WW'(i) == way_i) ages_o[i] = '0;
      else if (ages_i[i] < ages_i[way_i]) ages_o[i] = ages_i[i] + WW'(1);
      else ages_o[i] = ages_i[i];
    end
  end

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back, write-allocate cache, one word per line.
// Ports: clk, rst (async, active-high), bus (nway_wb_cache_if.slave).
// Hits complete combinationally in IDLE; misses go IDLE -> [WB] -> FILL -> IDLE
// and the held request then hits on the replay cycle (not counted as a hit).
module nway_wb_cache
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  parameter int AW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  nway_wb_cache_if.slave  bus
);

  localparam int WW   = clog2w(WAYS);
  localparam int IDXW = clog2w(SETS);
  localparam int TW   = AW - 2 - IDXW;

  state_e state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]         valid_q, dirty_q;
  logic [SETS-1:0][WAYS-1:0][WW-1:0] age_q;
  logic [TW-1:0] tag_q  [SETS][WAYS];
  logic [31:0]   data_q [SETS][WAYS];
  logic [31:0]   hit_cnt_q, miss_cnt_q;
  logic          replay_q;

  logic [IDXW-1:0]         idx_s;
  logic [TW-1:0]           tag_s;
  logic                    req_s, hit_s, hit_done_s, fill_done_s;
  logic [WW-1:0]           hit_way_s, victim_s, access_way_s;
  logic [WAYS-1:0][WW-1:0] ages_nxt_s;

  assign idx_s        = bus.cpu_addr[2+IDXW-1:2];
  assign tag_s        = bus.cpu_addr[AW-1:2+IDXW];
  assign req_s        = bus.cpu_re | bus.cpu_we;
  assign hit_done_s   = (state_q == IDLE) && req_s && hit_s;
  assign fill_done_s  = (state_q == FILL) && bus.mem_ack;
  assign access_way_s = fill_done_s ? victim_s : hit_way_s;

  // Tag lookup across the ways of the indexed set.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WW'(w);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  lru_ctrl #(.WAYS(WAYS), .WW(WW)) u_lru (
    .ages_i   (age_q[idx_s]),
    .valid_i  (valid_q[idx_s]),
    .way_i    (access_way_s),
    .ages_o   (ages_nxt_s),
    .victim_o (victim_s)
  );

  // Next state and CPU/memory outputs.
  always_comb begin
    state_d       = state_q;
    bus.cpu_rdata = data_q[idx_s][hit_way_s];
    bus.stall     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {bus.cpu_addr[AW-1:2], 2'b00};
    bus.mem_wdata = data_q[idx_s][victim_s];
    case (state_q)
      IDLE: begin
        if (req_s && !hit_s) begin
          bus.stall = 1'b1;
          if (valid_q[idx_s][victim_s] && dirty_q[idx_s][victim_s]) state_d = WB;
          else state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {tag_q[idx_s][victim_s], idx_s, 2'b00};
        if (bus.mem_ack) state_d = FILL;
        else state_d = WB;
      end
      FILL: begin
        bus.stall   = 1'b1;
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_d = IDLE;
        else state_d = FILL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, valid/dirty/age state and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      replay_q   <= 1'b0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WW'(w);
    end else begin
      state_q  <= state_d;
      replay_q <= fill_done_s;
      if (hit_done_s || fill_done_s) age_q[idx_s] <= ages_nxt_s;
      if (fill_done_s) begin
        valid_q[idx_s][victim_s] <= 1'b1;
        dirty_q[idx_s][victim_s] <= bus.cpu_we;
        miss_cnt_q               <= sat_inc(miss_cnt_q);
      end else if (hit_done_s) begin
        if (bus.cpu_we) dirty_q[idx_s][hit_way_s] <= 1'b1;
        // The replay after a fill is the same access, already counted as a miss.
        if (!replay_q) hit_cnt_q <= sat_inc(hit_cnt_q);
      end
    end
  end

  // Tag and data arrays carry no reset; only valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      tag_q[idx_s][victim_s]  <= tag_s;
      data_q[idx_s][victim_s] <= bus.cpu_we ? bus.cpu_wdata : bus.mem_rdata;
    end else if (hit_done_s && bus.cpu_we) begin
      data_q[idx_s][hit_way_s] <= bus.cpu_wdata;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

endmodule
